shift_reg_n: RTL and testbench
==============================

Name: shift_reg_n

Overview:
- Parameterisable serial-in/parallel-out shift register for the SPI datapath.
- Captures one serial bit per clock while shift_en is high and presents the accumulated word on data_out.
- Also provides a serial-out bit and a one-cycle word-complete strobe, so the SPI controller can frame bytes without its own bit counter.

Parameters:
- data_width, 8, word length in bits; legal range 2..64.
- lsb_first, 0, 0 = shift left (new bit enters bit 0, oldest bit at MSB); 1 = shift right (new bit enters bit data_width-1).
- reset_value, '0, value loaded into data_out on reset; data_width bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous, active-high reset. The port name is kept as the codebase names it; asserting 1 resets the block.
- shift_en  input  1  when 1 at a rising clk edge, one bit is shifted in.
- data_in  input  1  serial input bit, sampled at the rising clk edge when shift_en=1.
- data_out  output  data_width  parallel register contents.
- serial_out  output  1  bit about to be shifted out: data_out[data_width-1] when lsb_first=0, data_out[0] when lsb_first=1.
- word_valid  output  1  one-cycle strobe: the data_width-th bit of a word was captured on the previous edge.

Behaviour:
- Reset (rstn=1), asynchronous, takes effect immediately regardless of clk:
  - data_out = reset_value.
  - Internal bit counter = 0.
  - word_valid = 0.
- Reset held high: all state stays at reset values; shift_en and data_in are ignored.
- Reset release: synchronous in effect. The first capture happens on the first rising edge where rstn=0 and shift_en=1.
- Shift, lsb_first=0: on a rising edge with shift_en=1, data_out <= {data_out[data_width-2:0], data_in}. Latency is one cycle; the new bit is visible on data_out after that edge.
- Shift, lsb_first=1: data_out <= {data_in, data_out[data_width-1:1]}.
- shift_en=0: data_out holds. The counter holds. word_valid is 0 on the next cycle.
- Bit counter:
  - Width is clog2(data_width).
  - Increments on each shift and wraps from data_width-1 to 0.
  - On the edge that captures the bit with counter=data_width-1, word_valid is registered to 1 for exactly one cycle. It occurs coincident with data_out holding the complete word.
- Back-to-back words: continuous shift_en gives a word_valid pulse every data_width cycles, with no gap cycle.
- Reset mid-word: counter clears; the partial word is discarded; the next word is counted from bit 0.
- Reset asserted on the same edge as a shift: reset wins.
- serial_out is combinational from data_out and has no extra latency.
- No X propagation: all registers have defined reset values.

Decomposition:
- Shared package spi_pkg: holds the default width constant SPI_WORD_W=8 and a shift-direction enum (MSB_FIRST, LSB_FIRST) that maps to lsb_first.
- Optional sub-module shift_bit_counter: modulo-N counter with a terminal-count output, reusable by the SPI controller.

Test Plan:
- Reset: rstn=1 for 2 cycles with shift_en=1, data_in=1 -> data_out=8'h00, word_valid=0 throughout.
- Fill with ones (lsb_first=0): release reset, shift_en=1, data_in=1 for 8 edges -> data_out goes 01,03,07,0F,1F,3F,7F,FF; word_valid=1 only in the cycle data_out=FF.
- Pattern and hold: shift 1,0,1,1,0,0,1,0, then shift_en=0 for 3 cycles -> data_out=8'hB2 held; serial_out=1; no second word_valid.
- Reset mid-operation: after 4 ones (0F), assert rstn asynchronously between edges -> data_out=00 immediately; then 8 more ones -> FF with word_valid on the 8th bit, not the 4th.
- Repeated bursts: 5 iterations of (reset 1 cycle, 8 ones, deassert shift_en) -> FF and one word_valid per iteration.
- lsb_first=1: shift 1,0,0,0,0,0,0,0 -> data_out=8'h01, serial_out=1; continuous 16 shifts -> word_valid pulses at shifts 8 and 16.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI datapath definitions: default word width and shift-direction encoding.
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 8;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } shift_dir_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-N bit counter with a terminal-count flag; reusable by the SPI controller.
module shift_bit_counter #(
    parameter int unsigned modulus = 8,
    parameter int unsigned cnt_w   = (modulus > 1) ? $clog2(modulus) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic terminal
);

    localparam logic [cnt_w-1:0] LAST = cnt_w'(modulus - 1);

    logic [cnt_w-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/shift_reg_n.sv
// Serial-in/parallel-out shift register with serial-out tap and word-complete strobe.
module shift_reg_n
    import spi_pkg::*;
#(
    parameter int unsigned           data_width  = SPI_WORD_W,
    parameter bit                    lsb_first   = 1'b0,
    parameter logic [data_width-1:0] reset_value = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  shift_en,
    input  logic                  data_in,
    output logic [data_width-1:0] data_out,
    output logic                  serial_out,
    output logic                  word_valid
);

    localparam shift_dir_e DIR = lsb_first ? LSB_FIRST : MSB_FIRST;

    logic [data_width-1:0] shifted;
    logic                  last_bit;

    shift_bit_counter #(
        .modulus (data_width),
        .cnt_w   ($clog2(data_width))
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rstn),
        .en       (shift_en),
        .terminal (last_bit)
    );

    always_comb begin
        shifted = data_out;
        if (DIR == LSB_FIRST) begin
            shifted = {data_in, data_out[data_width-1:1]};
        end else begin
            shifted = {data_out[data_width-2:0], data_in};
        end
    end

    // The strobe lands on the same edge that writes the final bit, so it
    // coincides with data_out holding the complete word.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            data_out   <= reset_value;
            word_valid <= 1'b0;
        end else begin
            word_valid <= shift_en & last_bit;
            if (shift_en) begin
                data_out <= shifted;
            end
        end
    end

    assign serial_out = (DIR == LSB_FIRST) ? data_out[0] : data_out[data_width-1];

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed scoreboard bench for shift_reg_n in both shift directions.
module tb_shift_reg_n;

    typedef struct packed {
        logic [7:0] data;
        logic       wv;
        logic       ser;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0, din0 = 1'b0;
    logic       en1 = 1'b0, din1 = 1'b0;
    logic [7:0] dout0, dout1;
    logic       ser0, ser1, wv0, wv1;

    int vectors     = 0;
    int miscompares = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] m0_data = 8'h00;
    int         m0_cnt  = 0;
    logic [7:0] m1_data = 8'h00;
    int         m1_cnt  = 0;

    always #5 clk = ~clk;

    shift_reg_n #(
        .data_width  (8),
        .lsb_first   (1'b0),
        .reset_value (8'h00)
    ) dut0 (
        .clk        (clk),
        .rstn       (rst),
        .shift_en   (en0),
        .data_in    (din0),
        .data_out   (dout0),
        .serial_out (ser0),
        .word_valid (wv0)
    );

    shift_reg_n #(
        .data_width  (8),
        .lsb_first   (1'b1),
        .reset_value (8'h00)
    ) dut1 (
        .clk        (clk),
        .rstn       (rst),
        .shift_en   (en1),
        .data_in    (din1),
        .data_out   (dout1),
        .serial_out (ser1),
        .word_valid (wv1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step0(input logic en, input logic d);
        exp_t e;
        logic wv;
        en0  = en;
        din0 = d;
        wv   = 1'b0;
        if (en) begin
            wv      = (m0_cnt == 7);
            m0_data = {m0_data[6:0], d};
            m0_cnt  = (m0_cnt + 1) % 8;
        end
        e.data = m0_data;
        e.wv   = wv;
        e.ser  = m0_data[7];
        q0.push_back(e);
        @(posedge clk);
        #1;
        e = q0.pop_front();
        check("d0_data", 64'(dout0), 64'(e.data));
        check("d0_valid", 64'(wv0), 64'(e.wv));
        check("d0_serial", 64'(ser0), 64'(e.ser));
    endtask

    task automatic step1(input logic en, input logic d);
        exp_t e;
        logic wv;
        en1  = en;
        din1 = d;
        wv   = 1'b0;
        if (en) begin
            wv      = (m1_cnt == 7);
            m1_data = {d, m1_data[7:1]};
            m1_cnt  = (m1_cnt + 1) % 8;
        end
        e.data = m1_data;
        e.wv   = wv;
        e.ser  = m1_data[0];
        q1.push_back(e);
        @(posedge clk);
        #1;
        e = q1.pop_front();
        check("d1_data", 64'(dout1), 64'(e.data));
        check("d1_valid", 64'(wv1), 64'(e.wv));
        check("d1_serial", 64'(ser1), 64'(e.ser));
    endtask

    // Reset held with shift_en=1, data_in=1 to show reset overrides a shift.
    task automatic do_reset(input int cycles);
        rst  = 1'b1;
        en0  = 1'b1; din0 = 1'b1;
        en1  = 1'b1; din1 = 1'b1;
        #1;
        check("rst_async_d0", 64'(dout0), 64'h00);
        check("rst_async_d1", 64'(dout1), 64'h00);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_d0_data", 64'(dout0), 64'h00);
            check("rst_d0_valid", 64'(wv0), 64'h0);
            check("rst_d1_data", 64'(dout1), 64'h00);
            check("rst_d1_valid", 64'(wv1), 64'h0);
        end
        rst = 1'b0;
        en0 = 1'b0; din0 = 1'b0;
        en1 = 1'b0; din1 = 1'b0;
        m0_data = 8'h00; m0_cnt = 0;
        m1_data = 8'h00; m1_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        logic [7:0] pat;

        // Reset with shifting requested
        do_reset(2);

        // Fill with ones, MSB-first
        for (int i = 0; i < 8; i++) begin
            step0(1'b1, 1'b1);
            check("fill_data", 64'(dout0), 64'((1 << (i + 1)) - 1));
            check("fill_valid", 64'(wv0), 64'(i == 7));
        end

        // Pattern then hold
        do_reset(1);
        pat = 8'hB2;
        for (int i = 7; i >= 0; i--) begin
            step0(1'b1, pat[i]);
        end
        check("pat_data", 64'(dout0), 64'hB2);
        check("pat_valid", 64'(wv0), 64'h1);
        for (int i = 0; i < 3; i++) begin
            step0(1'b0, 1'b1);
            check("hold_data", 64'(dout0), 64'hB2);
            check("hold_serial", 64'(ser0), 64'h1);
            check("hold_valid", 64'(wv0), 64'h0);
        end

        // Asynchronous reset mid-word
        do_reset(1);
        for (int i = 0; i < 4; i++) step0(1'b1, 1'b1);
        check("mid_partial", 64'(dout0), 64'h0F);
        #2;
        rst = 1'b1;
        #1;
        check("mid_async_clear", 64'(dout0), 64'h00);
        check("mid_async_valid", 64'(wv0), 64'h0);
        @(posedge clk);
        #1;
        check("mid_held", 64'(dout0), 64'h00);
        rst = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        m0_data = 8'h00; m0_cnt = 0;
        m1_data = 8'h00; m1_cnt = 0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step0(1'b1, 1'b1);
            if (wv0) pulses++;
            check("mid_valid_pos", 64'(wv0), 64'(i == 7));
        end
        check("mid_final", 64'(dout0), 64'hFF);
        check("mid_pulses", 64'(pulses), 64'd1);

        // Repeated bursts
        for (int it = 0; it < 5; it++) begin
            do_reset(1);
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                step0(1'b1, 1'b1);
                if (wv0) pulses++;
            end
            check("burst_data", 64'(dout0), 64'hFF);
            step0(1'b0, 1'b0);
            if (wv0) pulses++;
            check("burst_pulses", 64'(pulses), 64'd1);
        end

        // LSB-first direction
        do_reset(1);
        step1(1'b1, 1'b1);
        check("lsb_first_bit", 64'(dout1), 64'h80);
        for (int i = 0; i < 7; i++) step1(1'b1, 1'b0);
        check("lsb_data", 64'(dout1), 64'h01);
        check("lsb_serial", 64'(ser1), 64'h1);
        check("lsb_valid", 64'(wv1), 64'h1);

        do_reset(1);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            step1(1'b1, 1'($urandom_range(0, 1)));
            if (wv1) pulses++;
            check("lsb_b2b_valid", 64'(wv1), 64'((i == 8) || (i == 16)));
        end
        check("lsb_b2b_pulses", 64'(pulses), 64'd2);
        step1(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
